// File: rtl/hsiao_ecc_pkg.sv
// rtl/hsiao_ecc_pkg.sv - Hsiao (39,32) SECDED code constants and scrubber state type.
package hsiao_ecc_pkg;

   localparam int unsigned HsiaoDataWidth  = 32;
   localparam int unsigned HsiaoProtWidth  = 7;
   localparam int unsigned HsiaoTotalWidth = HsiaoDataWidth + HsiaoProtWidth;

   typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} scrub_state_e;

   // H-matrix data columns: the 32 smallest weight-3 vectors; check bits use unit columns.
   localparam logic [HsiaoProtWidth-1:0] HsiaoCols [HsiaoDataWidth] = '{
      7'd7,  7'd11, 7'd13, 7'd14, 7'd19, 7'd21, 7'd22, 7'd25,
      7'd26, 7'd28, 7'd35, 7'd37, 7'd38, 7'd41, 7'd42, 7'd44,
      7'd49, 7'd50, 7'd52, 7'd56, 7'd67, 7'd69, 7'd70, 7'd73,
      7'd74, 7'd76, 7'd81, 7'd82, 7'd84, 7'd88, 7'd97, 7'd98
   };

endpackage

// File: rtl/hsiao_ecc_cor.sv
// rtl/hsiao_ecc_cor.sv - combinational Hsiao decode: syndrome, single-bit correction, error class.
module hsiao_ecc_cor
   import hsiao_ecc_pkg::*;
(
   input  logic [HsiaoTotalWidth-1:0] rdata,
   output logic [HsiaoTotalWidth-1:0] out,
   output logic [1:0]                 err_o
);

   logic [HsiaoProtWidth-1:0]  syndrome;
   logic [HsiaoTotalWidth-1:0] flip;

   always_comb begin
      syndrome = rdata[HsiaoTotalWidth-1:HsiaoDataWidth];
      for (int i = 0; i < HsiaoDataWidth; i++) begin
         if (rdata[i]) begin
            syndrome = syndrome ^ HsiaoCols[i];
         end
      end
   end

   always_comb begin
      flip = '0;
      for (int i = 0; i < HsiaoDataWidth; i++) begin
         flip[i] = (syndrome == HsiaoCols[i]);
      end
      for (int j = 0; j < HsiaoProtWidth; j++) begin
         flip[HsiaoDataWidth+j] = (syndrome == (HsiaoProtWidth'(1) << j));
      end
   end

   // An odd syndrome that matches no column is not correctable, so it is classed as a double.
   assign err_o[0] = |flip;
   assign err_o[1] = (|syndrome) & ~(|flip);
   assign out      = rdata ^ flip;

endmodule

// File: rtl/hsiao_ecc_scrubber.sv
// rtl/hsiao_ecc_scrubber.sv - background Hsiao scrubber for one SRAM bank.
// Optional saturating event counters are enabled by HSIAO_SCRUB_COUNTERS_EN.
module hsiao_ecc_scrubber
   import hsiao_ecc_pkg::*;
#(
   parameter int unsigned BankSize   = 256,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned ProtWidth  = $clog2(DataWidth) + 2,
   parameter int unsigned TotalWidth = DataWidth + ProtWidth,
   parameter int unsigned AddrWidth  = $clog2(BankSize)
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  scrub_trigger_i,
   input  logic                  intc_req_i,
   output logic                  bank_req_o,
   output logic                  bank_we_o,
   output logic [AddrWidth-1:0]  bank_add_o,
   output logic [TotalWidth-1:0] bank_wdata_o,
   input  logic                  bank_gnt_i,
   input  logic [TotalWidth-1:0] bank_rdata_i,
   input  logic                  bank_rvalid_i,
   output logic                  bar_corrected_o,
   output logic                  uncorrectable_o,
   output logic [31:0]           num_corrected_o,
   output logic [31:0]           num_uncorrectable_o
);

   scrub_state_e          state, state_next;
   logic [AddrWidth-1:0]  ptr, ptr_next;
   logic [TotalWidth-1:0] hold, hold_next;
   logic [TotalWidth-1:0] cor_out;
   logic [1:0]            err;
   logic                  cor_pulse, unc_pulse, advance;
   logic                  corrected, uncorrectable;

   hsiao_ecc_cor u_cor (
      .rdata (bank_rdata_i),
      .out   (cor_out),
      .err_o (err)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         ptr           <= '0;
         hold          <= '0;
         corrected     <= 1'b0;
         uncorrectable <= 1'b0;
      end else begin
         state         <= state_next;
         ptr           <= ptr_next;
         hold          <= hold_next;
         corrected     <= cor_pulse;
         uncorrectable <= unc_pulse;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      hold_next  = hold;
      cor_pulse  = 1'b0;
      unc_pulse  = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (scrub_trigger_i && !intc_req_i) begin
               state_next = READ;
            end
         end
         READ: begin
            if (bank_gnt_i) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (bank_rvalid_i) begin
               if (err[0]) begin
                  hold_next  = cor_out;
                  cor_pulse  = 1'b1;
                  state_next = WRITE;
               end else begin
                  unc_pulse  = err[1];
                  advance    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         WRITE: begin
            if (bank_gnt_i) begin
               advance    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Explicit wrap so non-power-of-two bank sizes walk 0..BankSize-1 only.
      if (advance) begin
         ptr_next = (ptr == AddrWidth'(BankSize - 1)) ? '0 : ptr + 1'b1;
      end
   end

   assign bank_req_o      = (state == READ) || (state == WRITE);
   assign bank_we_o       = (state == WRITE);
   assign bank_add_o      = ptr;
   assign bank_wdata_o    = hold;
   assign bar_corrected_o = corrected;
   assign uncorrectable_o = uncorrectable;

`ifdef HSIAO_SCRUB_COUNTERS_EN
   logic [31:0] cnt_cor, cnt_unc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_cor <= '0;
         cnt_unc <= '0;
      end else begin
         if (cor_pulse && (cnt_cor != 32'hFFFF_FFFF)) begin
            cnt_cor <= cnt_cor + 32'd1;
         end
         if (unc_pulse && (cnt_unc != 32'hFFFF_FFFF)) begin
            cnt_unc <= cnt_unc + 32'd1;
         end
      end
   end

   assign num_corrected_o     = cnt_cor;
   assign num_uncorrectable_o = cnt_unc;
`else
   assign num_corrected_o     = '0;
   assign num_uncorrectable_o = '0;
`endif

endmodule

// File: doc/hsiao_ecc_scrubber.md
Name: hsiao_ecc_scrubber

Overview:
- Background scrubber for one Hsiao-protected SRAM bank; sits between the bank's arbiter port and a decode stage it instantiates.
- Walks all addresses, reads each codeword and decodes it.
- Single-bit errors: corrected word is written back.
- Double-bit errors: flagged only.
- Yields to functional traffic. The bank arbiter gives intc priority.

Parameters:
- BankSize, 256, number of codewords in the bank.
- DataWidth, 32, payload bits per word.
- ProtWidth, $clog2(DataWidth)+2, parity bits.
- TotalWidth, DataWidth+ProtWidth, stored codeword width.
- AddrWidth, $clog2(BankSize), bank address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- scrub_trigger_i  in  1  level; while high, the scrubber may start a new word.
- intc_req_i  in  1  functional request pending on the bank; blocks new scrub starts.
- bank_req_o  out  1  scrub request to the bank arbiter.
- bank_we_o  out  1  1 = write, 0 = read.
- bank_add_o  out  AddrWidth  word address.
- bank_wdata_o  out  TotalWidth  corrected codeword for write-back.
- bank_gnt_i  in  1  grant.
- bank_rdata_i  in  TotalWidth  read codeword.
- bank_rvalid_i  in  1  read data valid, 1 cycle after gnt for reads.
- bar_corrected_o  out  1  one-cycle pulse: single error corrected.
- uncorrectable_o  out  1  one-cycle pulse: double error detected.
- num_corrected_o  out  32  correction count (optional feature).
- num_uncorrectable_o  out  32  uncorrectable count (optional feature).

Behaviour:
- Reset values: all outputs 0; address pointer 0; state IDLE; holding register 0.
- States: IDLE, READ, WAIT, WRITE.
- IDLE:
  - If scrub_trigger_i & ~intc_req_i: go to READ.
  - From the next cycle, drive bank_req_o=1, bank_we_o=0, bank_add_o=ptr.
- READ:
  - Hold req, we and add stable until bank_gnt_i.
  - intc_req_i rising after req is asserted does not withdraw the request.
  - On gnt: deassert req, go to WAIT.
- WAIT: on bank_rvalid_i, decode bank_rdata_i.
  - err=00: ptr++, go to IDLE.
  - err[0] (single): register the corrected codeword; pulse bar_corrected_o next cycle; go to WRITE.
  - err[1] (double): pulse uncorrectable_o next cycle; no write; ptr++, go to IDLE.
- WRITE:
  - req=1, we=1, add=same ptr, wdata=registered codeword (all fields registered).
  - Hold until gnt; then ptr++ and go to IDLE.
  - Write-response rvalid is ignored.
- Latency:
  - Read request appears 1 cycle after start.
  - For a correction, the write request is asserted the cycle after rvalid.
- Wrap-around: ptr == BankSize-1, then increment gives 0. BankSize need not be a power of two.
- Trigger deasserted mid-word: the current word completes, then the block stays in IDLE.
- Trigger pulses while busy are dropped; nothing is queued.
- Simultaneous trigger and intc_req_i in IDLE: no start.
- rvalid outside WAIT: ignored.
- Reset mid-operation: immediate return to reset values; no partial write. The next pass restarts at address 0.

Optional Feature:
- Macro: HSIAO_SCRUB_COUNTERS_EN.
- Defined: two 32-bit counters.
  - Each increments on the same cycle as its pulse.
  - Each saturates at 32'hFFFF_FFFF.
  - Both reset to 0.
- Undefined: num_corrected_o and num_uncorrectable_o are tied to '0 and no counter flops are inferred.

Decomposition:
- hsiao_ecc_pkg gains typedef enum logic [1:0] scrub_state_e {IDLE, READ, WAIT, WRITE}.
- Decode constants (matrices) stay in hsiao_ecc_pkg.
- One sub-module: hsiao_ecc_cor, instantiated combinationally on bank_rdata_i. Its err_o and out drive the FSM and the holding register.

Test Plan:
- Clean bank of BankSize=8: trigger held 1, intc 0, always-grant model. Addresses 0..7 are read in order, then wrap to 0. No writes. No pulses. Counters stay 0.
- Flip bit 5 of codeword at addr 3:
  - one write to addr 3 with the original encoded word, 1 cycle after rvalid;
  - bar_corrected_o pulses once; num_corrected_o = 1;
  - the next pass over addr 3 has no write.
- Flip bits 0 and 9 at addr 6: uncorrectable_o pulses once; no write; ptr advances to 7.
- intc_req_i=1 for 10 cycles in IDLE with trigger=1: bank_req_o stays 0. First read is issued 1 cycle after intc drops.
- Grant withheld 5 cycles during READ, with intc toggling: req, add and we are stable for all 5 cycles.
- Reset asserted in WRITE before gnt: req=0 immediately; after release, the first read is to addr 0.
